reg_bank: RTL and testbench

General-purpose register file of the multicycle MIPS datapath, directly downstream of the destination-register mux. It accepts the 5-bit write index produced by that mux (rt, rd, $sp=29 or $ra=31) together with write-back data, and provides two combinational read ports to the A/B operand registers. Reset brings the architectural state to its boot values. A sticky stack-guard flag reports $sp writes below a configured limit.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/reg_bank_guard.sv | 55 +++++
 rtl/reg_bank.sv | 87 ++++++++
 tb/tb_reg_bank.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg
//   Constants shared by the multicycle MIPS datapath: register indices with
//   architectural meaning, datapath widths, and the write-counter width.
//   Both the register file and the destination-register mux import these
//   so that $zero, $sp and $ra are never written as bare numbers.
package mips_pkg;

    localparam int WORD_W    = 32;
    localparam int REG_IDX_W = 5;
    localparam int CNT_W     = 16;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_IDX_W-1:0] REG_SP   = 5'd29;
    localparam logic [REG_IDX_W-1:0] REG_RA   = 5'd31;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // A write only changes architectural state when enabled and not aimed
    // at $zero.
    function automatic logic is_commit(input logic                 wr_en,
                                       input logic [REG_IDX_W-1:0] idx);
        return wr_en && (idx != REG_ZERO);
    endfunction

endpackage

// File: rtl/reg_bank_guard.sv
// reg_bank_guard
//   Bookkeeping that sits beside the register array:
//   - sticky stack-guard flag, set by any committed $sp write whose data is
//     below STACK_LIMIT (unsigned), cleared only by reset;
//   - saturating count of committed writes.
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high
//   commit_i    in   a write to a non-zero index happens on this edge
//   idx_i       in   index being written
//   data_i      in   data being written
//   sp_guard_o  out  sticky stack-guard flag
//   wr_count_o  out  committed-write count, holds at all-ones
module reg_bank_guard
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] STACK_LIMIT = 32'd0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 commit_i,
    input  logic [REG_IDX_W-1:0] idx_i,
    input  logic [WORD_W-1:0]    data_i,
    output logic                 sp_guard_o,
    output logic [CNT_W-1:0]     wr_count_o
);

    logic             sp_guard_q, sp_guard_d;
    logic [CNT_W-1:0] wr_count_q, wr_count_d;

    always_comb begin
        sp_guard_d = sp_guard_q;
        wr_count_d = wr_count_q;
        if (commit_i && (idx_i == REG_SP) && (data_i < STACK_LIMIT)) begin
            sp_guard_d = 1'b1;
        end
        if (commit_i && (wr_count_q != CNT_MAX)) begin
            wr_count_d = wr_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_guard_q <= 1'b0;
            wr_count_q <= '0;
        end else begin
            sp_guard_q <= sp_guard_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign sp_guard_o = sp_guard_q;
    assign wr_count_o = wr_count_q;

endmodule

// File: rtl/reg_bank.sv
// reg_bank
//   General-purpose register file of the multicycle MIPS datapath.
//   31 stored 32-bit registers (indices 1..31); index 0 reads as zero and
//   ignores writes. Two combinational read ports with optional same-cycle
//   write bypass. Reset loads $sp with SP_RESET and everything else with 0.
// Parameters:
//   SP_RESET     reset value of $sp
//   STACK_LIMIT  lowest legal $sp value for the stack guard
//   BYPASS       1: reads of the index being written return WriteData
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   RegWrite            write enable
//   ReadReg1/ReadReg2   read indices (rs / rt)
//   WriteReg/WriteData  write index (from dest mux) and write-back data
//   ReadData1/ReadData2 read data
//   sp_guard            sticky $sp-below-limit flag
//   wr_count            committed writes since reset, saturating
module reg_bank
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] SP_RESET    = 32'd227,
    parameter logic [WORD_W-1:0] STACK_LIMIT = 32'd0,
    parameter bit                BYPASS      = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RegWrite,
    input  logic [REG_IDX_W-1:0] ReadReg1,
    input  logic [REG_IDX_W-1:0] ReadReg2,
    input  logic [REG_IDX_W-1:0] WriteReg,
    input  logic [WORD_W-1:0]    WriteData,
    output logic [WORD_W-1:0]    ReadData1,
    output logic [WORD_W-1:0]    ReadData2,
    output logic                 sp_guard,
    output logic [CNT_W-1:0]     wr_count
);

    logic              commit;
    logic [WORD_W-1:0] regs_q [1:31];
    // Full 32-entry read view so both read muxes index in range; entry 0 is
    // the hardwired $zero.
    logic [WORD_W-1:0] rd_view [32];

    assign commit     = is_commit(RegWrite, WriteReg);
    assign rd_view[0] = '0;

    for (genvar g = 1; g < 32; g++) begin : g_reg
        localparam logic [REG_IDX_W-1:0] IDX     = REG_IDX_W'(g);
        localparam logic [WORD_W-1:0]    RST_VAL = (IDX == REG_SP) ? SP_RESET : '0;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                regs_q[g] <= RST_VAL;
            end else if (commit && (WriteReg == IDX)) begin
                regs_q[g] <= WriteData;
            end
        end

        assign rd_view[g] = regs_q[g];
    end

    // A non-zero read index that matches an enabled write index sees the
    // incoming data when bypass is built in; $zero is never bypassed.
    always_comb begin
        ReadData1 = rd_view[ReadReg1];
        ReadData2 = rd_view[ReadReg2];
        if (BYPASS && commit && (ReadReg1 == WriteReg)) begin
            ReadData1 = WriteData;
        end
        if (BYPASS && commit && (ReadReg2 == WriteReg)) begin
            ReadData2 = WriteData;
        end
    end

    reg_bank_guard #(
        .STACK_LIMIT(STACK_LIMIT)
    ) u_guard (
        .clk        (clk),
        .reset      (reset),
        .commit_i   (commit),
        .idx_i      (WriteReg),
        .data_i     (WriteData),
        .sp_guard_o (sp_guard),
        .wr_count_o (wr_count)
    );

endmodule

// File: tb/tb_reg_bank.sv
module tb_reg_bank;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write;
  logic [4:0]  read_reg1, read_reg2, write_reg;
  logic [31:0] write_data;

  // Instance with bypass and a stack limit of 100.
  logic [31:0] rd1, rd2;
  logic        guard;
  logic [15:0] count;
  // Instance without bypass, default stack limit 0.
  logic [31:0] rd1_nb, rd2_nb;
  logic        guard_nb;
  logic [15:0] count_nb;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  reg_bank #(.SP_RESET(32'd227), .STACK_LIMIT(32'd100), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .RegWrite(reg_write),
    .ReadReg1(read_reg1), .ReadReg2(read_reg2),
    .WriteReg(write_reg), .WriteData(write_data),
    .ReadData1(rd1), .ReadData2(rd2),
    .sp_guard(guard), .wr_count(count)
  );

  reg_bank #(.SP_RESET(32'd227), .STACK_LIMIT(32'd0), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .RegWrite(reg_write),
    .ReadReg1(read_reg1), .ReadReg2(read_reg2),
    .WriteReg(write_reg), .WriteData(write_data),
    .ReadData1(rd1_nb), .ReadData2(rd2_nb),
    .sp_guard(guard_nb), .wr_count(count_nb)
  );

  // ---------------- scoreboard ----------------
  // Signal selectors for expected entries.
  localparam int S_RD1 = 0, S_RD2 = 1, S_GRD = 2, S_CNT = 3;
  localparam int S_RD1_NB = 4, S_RD2_NB = 5, S_GRD_NB = 6, S_CNT_NB = 7;

  logic [W-1:0] exp_q[$];
  int           sel_q[$];
  string        name_q[$];
  int           n_cmp = 0;
  int           n_err = 0;

  function automatic logic [W-1:0] observe(input int sel);
    case (sel)
      S_RD1:    return rd1;
      S_RD2:    return rd2;
      S_GRD:    return {31'd0, guard};
      S_CNT:    return {16'd0, count};
      S_RD1_NB: return rd1_nb;
      S_RD2_NB: return rd2_nb;
      S_GRD_NB: return {31'd0, guard_nb};
      default:  return {16'd0, count_nb};
    endcase
  endfunction

  task automatic expect_val(input int sel, input logic [W-1:0] v, input string nm);
    exp_q.push_back(v);
    sel_q.push_back(sel);
    name_q.push_back(nm);
  endtask

  task automatic check_now(input int sel, input logic [W-1:0] v, input string nm);
    logic [W-1:0] a;
    a = observe(sel);
    n_cmp++;
    if (a !== v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, a, v);
    end
  endtask

  // Monitor: outputs are settled mid-cycle; drain every expectation issued
  // since the last rising edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      int           s;
      string        nm;
      e  = exp_q.pop_front();
      s  = sel_q.pop_front();
      nm = name_q.pop_front();
      a  = observe(s);
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", nm, a, e);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    reg_write  = we;
    write_reg  = wr;
    write_data = wd;
    read_reg1  = r1;
    read_reg2  = r2;
  endtask

  task automatic expect_both_rd(input logic [31:0] a1, input logic [31:0] a2,
                                input logic [31:0] b1, input logic [31:0] b2,
                                input string nm);
    expect_val(S_RD1, a1, {nm, "_rd1"});
    expect_val(S_RD2, a2, {nm, "_rd2"});
    expect_val(S_RD1_NB, b1, {nm, "_rd1_nb"});
    expect_val(S_RD2_NB, b2, {nm, "_rd2_nb"});
  endtask

  task automatic expect_stat(input logic g, input logic gnb, input logic [15:0] c,
                             input string nm);
    expect_val(S_GRD, {31'd0, g}, {nm, "_guard"});
    expect_val(S_GRD_NB, {31'd0, gnb}, {nm, "_guard_nb"});
    expect_val(S_CNT, {16'd0, c}, {nm, "_count"});
    expect_val(S_CNT_NB, {16'd0, c}, {nm, "_count_nb"});
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

    // Reset: every index reads 0 except $sp = 227, on both ports.
    for (int i = 0; i < 32; i++) begin
      logic [31:0] ev;
      step();
      ev = (i == 29) ? 32'd227 : 32'd0;
      drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
      expect_val(S_RD1, ev, $sformatf("reset_rd1_%0d", i));
      expect_val(S_RD2_NB, (31 - i == 29) ? 32'd227 : 32'd0, $sformatf("reset_rd2nb_%0d", 31 - i));
    end
    expect_stat(1'b0, 1'b0, 16'd0, "reset");

    step();
    drive(1'b0, 5'd0, 32'd0, 5'd29, 5'd29);
    #1;
    check_now(S_GRD, 32'd0, "reset_now_guard");
    check_now(S_GRD_NB, 32'd0, "reset_now_guard_nb");
    check_now(S_CNT, 32'd0, "reset_now_count");
    check_now(S_CNT_NB, 32'd0, "reset_now_count_nb");
    check_now(S_RD1, 32'd227, "reset_now_sp_rd1");
    check_now(S_RD2_NB, 32'd227, "reset_now_sp_rd2_nb");
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

    // Write 8 with reads of 8: bypassed instance sees new data, other old.
    step();
    drive(1'b1, 5'd8, 32'hDEADBEEF, 5'd8, 5'd8);
    expect_both_rd(32'hDEADBEEF, 32'hDEADBEEF, 32'd0, 32'd0, "wr8_same");

    // Write $ra (jal path); reg 8 now stored in both.
    step();
    drive(1'b1, 5'd31, 32'h1, 5'd8, 5'd31);
    expect_both_rd(32'hDEADBEEF, 32'h1, 32'hDEADBEEF, 32'd0, "wr31_same");
    expect_stat(1'b0, 1'b0, 16'd1, "after_wr8");

    step();
    drive(1'b0, 5'd0, 32'd0, 5'd8, 5'd31);
    expect_both_rd(32'hDEADBEEF, 32'h1, 32'hDEADBEEF, 32'h1, "rd_8_31");
    expect_stat(1'b0, 1'b0, 16'd2, "after_wr31");

    // $zero write: no bypass, no store, no count.
    step();
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    expect_both_rd(32'd0, 32'd0, 32'd0, 32'd0, "zero_same");
    step();
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    expect_both_rd(32'd0, 32'd0, 32'd0, 32'd0, "zero_after");
    expect_stat(1'b0, 1'b0, 16'd2, "zero_after");

    // Bypass on both ports simultaneously.
    step();
    drive(1'b1, 5'd5, 32'h1234, 5'd5, 5'd5);
    expect_both_rd(32'h1234, 32'h1234, 32'd0, 32'd0, "byp_same");
    step();
    drive(1'b0, 5'd5, 32'h9999, 5'd5, 5'd5);
    expect_both_rd(32'h1234, 32'h1234, 32'h1234, 32'h1234, "byp_after_we0");
    expect_stat(1'b0, 1'b0, 16'd3, "byp_after");

    // Stack guard: 50 < 100 sets it in the limited instance only.
    step();
    drive(1'b1, 5'd29, 32'd50, 5'd29, 5'd8);
    expect_both_rd(32'd50, 32'hDEADBEEF, 32'd227, 32'hDEADBEEF, "sp50_same");
    expect_stat(1'b0, 1'b0, 16'd3, "sp50_same");
    step();
    drive(1'b1, 5'd29, 32'd200, 5'd8, 5'd8);
    expect_stat(1'b1, 1'b0, 16'd4, "sp50_after");
    step();
    drive(1'b0, 5'd0, 32'd0, 5'd29, 5'd29);
    expect_both_rd(32'd200, 32'd200, 32'd200, 32'd200, "sp200_after");
    expect_stat(1'b1, 1'b0, 16'd5, "sp200_after");

    // Asynchronous reset pulse between edges.
    step();
    drive(1'b0, 5'd0, 32'd0, 5'd29, 5'd8);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    expect_both_rd(32'd227, 32'd0, 32'd227, 32'd0, "async_rst");
    expect_stat(1'b0, 1'b0, 16'd0, "async_rst");

    // Counter saturation: 65534 writes, then two more.
    step();
    drive(1'b1, 5'd1, 32'hA5A50001, 5'd1, 5'd0);
    repeat (65533) @(posedge clk);
    #1;
    expect_stat(1'b0, 1'b0, 16'd65533, "cnt_65533");
    step();
    expect_stat(1'b0, 1'b0, 16'hFFFE, "cnt_fffe");
    step();
    expect_stat(1'b0, 1'b0, 16'hFFFF, "cnt_ffff");
    step();
    drive(1'b0, 5'd0, 32'd0, 5'd1, 5'd0);
    expect_stat(1'b0, 1'b0, 16'hFFFF, "cnt_sat");
    expect_both_rd(32'hA5A50001, 32'd0, 32'hA5A50001, 32'd0, "cnt_reg1");

    step();
    step();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL expired_wait: %0d expectations never checked", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
